// File: rtl/usb_buffer_arbiter.sv
// Arbitrates a shared single-port USB data buffer RAM between the core and the USB engine.
// Buffer ownership decides who may write; reads are always allowed, and a starving non-owner eventually wins.
module usb_buffer_arbiter #(
    parameter int BUFFER_WORDS = 255,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk48,
    input  logic        reset_n,
    input  logic        core_req,
    input  logic [7:0]  core_addr,
    input  logic [31:0] core_wdata,
    input  logic [3:0]  core_wstrb,
    output logic        core_grant,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    input  logic        usb_req,
    input  logic [7:0]  usb_addr,
    input  logic [31:0] usb_wdata,
    input  logic        usb_write,
    output logic        usb_grant,
    output logic        usb_rvalid,
    output logic [31:0] usb_rdata,
    input  logic        got_packet,
    input  logic        release_buf,
    output logic        owner,
    output logic [7:0]  ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wstrb,
    input  logic [31:0] ram_rdata,
    output logic        violation,
    input  logic        violation_clear
);

    typedef enum logic {USB_OWNS = 1'b0, CORE_OWNS = 1'b1} own_state_t;

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(STARVE_LIMIT);
    localparam logic [8:0] WORDS = 9'(BUFFER_WORDS);

    own_state_t    state_q, state_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          violation_q, violation_d;
    logic          core_pend_q, core_pend_d;
    logic          usb_pend_q, usb_pend_d;
    logic          oob_pend_q, oob_pend_d;

    logic          core_is_owner, starved, granted;
    logic          acc_write, acc_owner, acc_oob;
    logic [3:0]    acc_strb;
    logic          non_owner_req, non_owner_grant, viol_set;

    // got_packet has priority over release when both arrive together
    always_comb begin
        state_d = state_q;
        if (got_packet) begin
            state_d = CORE_OWNS;
        end else if (release_buf) begin
            state_d = USB_OWNS;
        end
    end

    always_comb begin
        core_is_owner = (state_q == CORE_OWNS);
        starved       = (stall_q == STALL_MAX);
        core_grant    = 1'b0;
        usb_grant     = 1'b0;
        if (reset_n) begin
            if (core_req && usb_req) begin
                if (core_is_owner != starved) begin
                    core_grant = 1'b1;
                end else begin
                    usb_grant = 1'b1;
                end
            end else begin
                core_grant = core_req;
                usb_grant  = usb_req;
            end
        end
    end

    always_comb begin
        ram_addr  = 8'd0;
        ram_wdata = 32'd0;
        ram_wstrb = 4'd0;
        acc_write = 1'b0;
        acc_owner = 1'b0;
        acc_strb  = 4'd0;
        granted   = core_grant | usb_grant;
        if (core_grant) begin
            ram_addr  = core_addr;
            ram_wdata = core_wdata;
            acc_write = |core_wstrb;
            acc_owner = core_is_owner;
            acc_strb  = core_wstrb;
        end else if (usb_grant) begin
            ram_addr  = usb_addr;
            ram_wdata = usb_wdata;
            acc_write = usb_write;
            acc_owner = !core_is_owner;
            acc_strb  = 4'b1111;
        end
        acc_oob = granted && ({1'b0, ram_addr} >= WORDS);
        // Illegal writes still consume the grant but never reach the RAM
        if (granted && acc_write && acc_owner && !acc_oob) begin
            ram_wstrb = acc_strb;
        end
        viol_set    = granted && (acc_oob || (acc_write && !acc_owner));
        violation_d = viol_set | (violation_q & ~violation_clear);
        core_pend_d = core_grant && !acc_write;
        usb_pend_d  = usb_grant && !acc_write;
        oob_pend_d  = acc_oob && !acc_write;
    end

    always_comb begin
        non_owner_req   = core_is_owner ? usb_req : core_req;
        non_owner_grant = core_is_owner ? usb_grant : core_grant;
        stall_d         = stall_q;
        if ((state_d != state_q) || non_owner_grant) begin
            stall_d = '0;
        end else if (non_owner_req && !starved) begin
            stall_d = stall_q + SW'(1);
        end
    end

    always_ff @(posedge clk48 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= USB_OWNS;
            stall_q     <= '0;
            violation_q <= 1'b0;
            core_pend_q <= 1'b0;
            usb_pend_q  <= 1'b0;
            oob_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_q     <= stall_d;
            violation_q <= violation_d;
            core_pend_q <= core_pend_d;
            usb_pend_q  <= usb_pend_d;
            oob_pend_q  <= oob_pend_d;
        end
    end

    assign owner       = (state_q == CORE_OWNS);
    assign violation   = violation_q;
    assign core_rvalid = core_pend_q;
    assign usb_rvalid  = usb_pend_q;
    assign core_rdata  = (core_pend_q && !oob_pend_q) ? ram_rdata : 32'd0;
    assign usb_rdata   = (usb_pend_q && !oob_pend_q) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// Self-checking bench for usb_buffer_arbiter: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a behavioural model of ownership, arbitration and buffer contents.
module tb_usb_buffer_arbiter;

    localparam int LIMIT = 4;
    localparam int WORDS = 255;

    logic        clk48, reset_n;
    logic        core_req, usb_req, usb_write, got_packet, release_buf, violation_clear;
    logic [7:0]  core_addr, usb_addr, ram_addr;
    logic [31:0] core_wdata, usb_wdata, ram_wdata, ram_rdata, core_rdata, usb_rdata;
    logic [3:0]  core_wstrb, ram_wstrb;
    logic        core_grant, usb_grant, core_rvalid, usb_rvalid, owner, violation;

    logic [31:0] ram [256];
    logic [31:0] refMem [256];

    bit          refOwner, refViol;
    int          refStall, pendWho;
    logic [31:0] pendData;
    bit          lastCoreGrant, lastUsbGrant;
    int          checks = 0;
    int          errors = 0;

    usb_buffer_arbiter #(.BUFFER_WORDS(WORDS), .STARVE_LIMIT(LIMIT)) dut (
        .clk48(clk48), .reset_n(reset_n),
        .core_req(core_req), .core_addr(core_addr), .core_wdata(core_wdata), .core_wstrb(core_wstrb),
        .core_grant(core_grant), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .usb_req(usb_req), .usb_addr(usb_addr), .usb_wdata(usb_wdata), .usb_write(usb_write),
        .usb_grant(usb_grant), .usb_rvalid(usb_rvalid), .usb_rdata(usb_rdata),
        .got_packet(got_packet), .release_buf(release_buf), .owner(owner),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata),
        .violation(violation), .violation_clear(violation_clear)
    );

    initial clk48 = 1'b0;
    always #5 clk48 = ~clk48;

    // Byte-enabled RAM with one-cycle registered read, driven purely by the DUT's RAM port
    always @(posedge clk48) begin
        for (int b = 0; b < 4; b++)
            if (ram_wstrb[b]) ram[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        ram_rdata <= ram[ram_addr];
    end

    task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task applyStimulus(input bit cReq, input logic [7:0] cAddr, input logic [31:0] cData,
                       input logic [3:0] cStrb, input bit uReq, input logic [7:0] uAddr,
                       input logic [31:0] uData, input bit uWr, input bit gp, input bit rel,
                       input bit vc);
        core_req = cReq;  core_addr = cAddr; core_wdata = cData; core_wstrb = cStrb;
        usb_req = uReq;   usb_addr = uAddr;  usb_wdata = uData;  usb_write = uWr;
        got_packet = gp;  release_buf = rel; violation_clear = vc;
    endtask

    task applyIdle;
        applyStimulus(0, 8'd0, 32'd0, 4'd0, 0, 8'd0, 32'd0, 0, 0, 0, 0);
    endtask

    // Called 1 time unit after a rising edge with inputs already applied: checks this cycle, advances the model
    task stepCycle;
        bit          eCG, eUG, granted, isWr, isOwn, inRange, newOwner, newViol, nonOwnerReq, nonOwnerGrant;
        int          addr;
        logic [3:0]  strb, eStrb;
        logic [31:0] wd;
        #3;
        if (core_req && usb_req)
            eCG = refOwner ? (refStall != LIMIT) : (refStall == LIMIT);
        else
            eCG = core_req;
        eUG = usb_req && !eCG;
        granted = eCG || eUG;
        addr = 0; isWr = 0; isOwn = 0; strb = 4'd0; wd = 32'd0;
        if (eCG) begin
            addr = int'(core_addr); isWr = (core_wstrb != 0); isOwn = refOwner;
            strb = core_wstrb; wd = core_wdata;
        end else if (eUG) begin
            addr = int'(usb_addr); isWr = usb_write; isOwn = !refOwner;
            strb = 4'hF; wd = usb_wdata;
        end
        inRange = addr < WORDS;
        eStrb = (granted && isWr && isOwn && inRange) ? strb : 4'd0;

        checkOutput("core_grant", core_grant, eCG);
        checkOutput("usb_grant", usb_grant, eUG);
        checkOutput("ram_wstrb", ram_wstrb, eStrb);
        checkOutput("owner", owner, refOwner);
        checkOutput("violation", violation, refViol);
        checkOutput("core_rvalid", core_rvalid, pendWho == 1);
        checkOutput("usb_rvalid", usb_rvalid, pendWho == 2);
        checkOutput("core_rdata", core_rdata, (pendWho == 1) ? pendData : 32'd0);
        checkOutput("usb_rdata", usb_rdata, (pendWho == 2) ? pendData : 32'd0);
        if (granted) checkOutput("ram_addr", ram_addr, addr);
        if (eStrb != 0) checkOutput("ram_wdata", ram_wdata, wd);

        pendWho  = (granted && !isWr) ? (eCG ? 1 : 2) : 0;
        pendData = inRange ? refMem[addr] : 32'd0;
        for (int b = 0; b < 4; b++)
            if (eStrb[b]) refMem[addr][b*8 +: 8] = wd[b*8 +: 8];
        newViol = granted && (!inRange || (isWr && !isOwn));
        refViol = newViol || (refViol && !violation_clear);
        newOwner = got_packet ? 1'b1 : (release_buf ? 1'b0 : refOwner);
        nonOwnerReq   = refOwner ? usb_req : core_req;
        nonOwnerGrant = refOwner ? eUG : eCG;
        if (newOwner != refOwner || nonOwnerGrant) refStall = 0;
        else if (nonOwnerReq && refStall < LIMIT) refStall++;
        refOwner = newOwner;
        lastCoreGrant = eCG;
        lastUsbGrant  = eUG;
        @(posedge clk48);
        #1;
    endtask

    // Reset asserted with requests pending; everything visible must be quiet while it is held
    task doReset;
        reset_n = 1'b0;
        applyStimulus(1, 8'd3, 32'h1234_5678, 4'hF, 1, 8'd4, 32'h0BAD_F00D, 1, 0, 0, 0);
        #2;
        checkOutput("rst_core_grant", core_grant, 0);
        checkOutput("rst_usb_grant", usb_grant, 0);
        checkOutput("rst_ram_wstrb", ram_wstrb, 0);
        checkOutput("rst_owner", owner, 0);
        checkOutput("rst_violation", violation, 0);
        checkOutput("rst_core_rvalid", core_rvalid, 0);
        checkOutput("rst_usb_rvalid", usb_rvalid, 0);
        checkOutput("rst_core_rdata", core_rdata, 0);
        checkOutput("rst_usb_rdata", usb_rdata, 0);
        refOwner = 0; refViol = 0; refStall = 0; pendWho = 0; pendData = 32'd0;
        repeat (2) @(posedge clk48);
        #1;
        reset_n = 1'b1;
        applyIdle();
    endtask

    task randomTraffic(input int cycles);
        bit cReq, uReq, uWr;
        logic [7:0] cAddr, uAddr;
        logic [31:0] cData, uData;
        logic [3:0] cStrb;
        cReq = 0; uReq = 0; uWr = 0; cAddr = 0; uAddr = 0; cData = 0; uData = 0; cStrb = 0;
        for (int i = 0; i < cycles; i++) begin
            // Requesters hold their transaction until the model says it was granted
            if (!cReq || lastCoreGrant) begin
                cReq  = $urandom_range(0, 99) < 60;
                cAddr = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 15));
                cStrb = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                cData = $urandom;
            end
            if (!uReq || lastUsbGrant) begin
                uReq  = $urandom_range(0, 99) < 60;
                uAddr = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 15));
                uWr   = $urandom_range(0, 1) == 1;
                uData = $urandom;
            end
            applyStimulus(cReq, cAddr, cData, cStrb, uReq, uAddr, uData, uWr,
                          $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 6,
                          $urandom_range(0, 99) < 10);
            stepCycle();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = 32'd0;
            refMem[i] = 32'd0;
        end
        lastCoreGrant = 0; lastUsbGrant = 0;
        reset_n = 1'b0;
        applyIdle();
        @(posedge clk48);
        #1;
        doReset();

        // USB engine writes a word while it owns the buffer
        applyStimulus(0, 8'd0, 32'd0, 4'd0, 1, 8'd5, 32'hDEAD_BEEF, 1, 0, 0, 0);
        stepCycle();

        // Hand the buffer to the core, then the core reads the word back
        applyStimulus(0, 8'd0, 32'd0, 4'd0, 0, 8'd0, 32'd0, 0, 1, 0, 0);
        stepCycle();
        applyStimulus(1, 8'd5, 32'd0, 4'd0, 0, 8'd0, 32'd0, 0, 0, 0, 0);
        stepCycle();
        applyIdle();
        stepCycle();

        // Both request continuously while the core owns: starvation hand-off to USB
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 8'd1, 32'd0, 4'd0, 1, 8'd2, 32'd0, 0, 0, 0, 0);
            stepCycle();
        end

        // Give the buffer back, then the core attempts an illegal partial write
        applyStimulus(0, 8'd0, 32'd0, 4'd0, 0, 8'd0, 32'd0, 0, 0, 1, 0);
        stepCycle();
        applyStimulus(1, 8'd2, 32'hCAFE_F00D, 4'b0011, 0, 8'd0, 32'd0, 0, 0, 0, 0);
        stepCycle();
        applyIdle();
        repeat (2) stepCycle();
        applyStimulus(0, 8'd0, 32'd0, 4'd0, 0, 8'd0, 32'd0, 0, 0, 0, 1);
        stepCycle();
        applyIdle();
        stepCycle();

        // Simultaneous got_packet and release from USB ownership
        applyStimulus(0, 8'd0, 32'd0, 4'd0, 0, 8'd0, 32'd0, 0, 1, 1, 0);
        stepCycle();
        applyIdle();
        stepCycle();

        // Out-of-range read by USB
        applyStimulus(0, 8'd0, 32'd0, 4'd0, 1, 8'd255, 32'd0, 0, 0, 0, 0);
        stepCycle();
        applyIdle();
        repeat (2) stepCycle();

        // Reset lands while a read return is pending
        applyStimulus(1, 8'd5, 32'd0, 4'd0, 0, 8'd0, 32'd0, 0, 0, 0, 0);
        stepCycle();
        doReset();
        repeat (2) stepCycle();

        randomTraffic(800);
        doReset();
        randomTraffic(800);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
